// File: rtl/cop_mem_arbiter.sv
// Two-requester arbiter for the single COP memory port: combinational issue, 1-cycle response,
// issued request held stable through stalls, responses routed back to the owning requester.
module cop_mem_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        rq0_cen,
    input  logic        rq0_wen,
    input  logic [31:0] rq0_addr,
    input  logic [31:0] rq0_wdata,
    input  logic [3:0]  rq0_ben,
    output logic        rq0_gnt,
    output logic        rq0_rsp,
    output logic [31:0] rq0_rdata,
    output logic        rq0_error,

    input  logic        rq1_cen,
    input  logic        rq1_wen,
    input  logic [31:0] rq1_addr,
    input  logic [31:0] rq1_wdata,
    input  logic [3:0]  rq1_ben,
    output logic        rq1_gnt,
    output logic        rq1_rsp,
    output logic [31:0] rq1_rdata,
    output logic        rq1_error,

    output logic        cop_mem_cen,
    output logic        cop_mem_wen,
    output logic [31:0] cop_mem_addr,
    output logic [31:0] cop_mem_wdata,
    output logic [3:0]  cop_mem_ben,
    input  logic [31:0] cop_mem_rdata,
    input  logic        cop_mem_stall,
    input  logic        cop_mem_error
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        hold_wen_q, hold_wen_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic [3:0]  hold_ben_q, hold_ben_d;

    logic        busy, can_issue, issue, stall, complete, sel;
    logic        sel_wen;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_ben;

    // Every output is gated by g_reset so the port is quiet while reset is asserted.
    always_comb begin
        busy      = (state_q == ST_BUSY);
        can_issue = !busy || !cop_mem_stall;
        if (rq0_cen && rq1_cen) begin
            sel = (FIXED_PRIO != 0) ? 1'b0 : !last_q;
        end else begin
            sel = rq1_cen;
        end
        issue     = !g_reset && can_issue && (rq0_cen || rq1_cen);
        stall     = !g_reset && busy && cop_mem_stall;
        complete  = !g_reset && busy && !cop_mem_stall;
        sel_wen   = sel ? rq1_wen   : rq0_wen;
        sel_addr  = sel ? rq1_addr  : rq0_addr;
        sel_wdata = sel ? rq1_wdata : rq0_wdata;
        sel_ben   = sel ? rq1_ben   : rq0_ben;
    end

    always_comb begin
        cop_mem_cen   = 1'b0;
        cop_mem_wen   = 1'b0;
        cop_mem_addr  = '0;
        cop_mem_wdata = '0;
        cop_mem_ben   = '0;
        rq0_gnt       = 1'b0;
        rq1_gnt       = 1'b0;
        rq0_rsp       = 1'b0;
        rq0_rdata     = '0;
        rq0_error     = 1'b0;
        rq1_rsp       = 1'b0;
        rq1_rdata     = '0;
        rq1_error     = 1'b0;
        if (stall) begin
            cop_mem_cen   = 1'b1;
            cop_mem_wen   = hold_wen_q;
            cop_mem_addr  = hold_addr_q;
            cop_mem_wdata = hold_wdata_q;
            cop_mem_ben   = hold_ben_q;
        end else if (issue) begin
            cop_mem_cen   = 1'b1;
            cop_mem_wen   = sel_wen;
            cop_mem_addr  = sel_addr;
            cop_mem_wdata = sel_wdata;
            cop_mem_ben   = sel_ben;
            rq0_gnt       = !sel;
            rq1_gnt       = sel;
        end
        if (complete && !owner_q) begin
            rq0_rsp   = 1'b1;
            rq0_rdata = cop_mem_rdata;
            rq0_error = cop_mem_error;
        end
        if (complete && owner_q) begin
            rq1_rsp   = 1'b1;
            rq1_rdata = cop_mem_rdata;
            rq1_error = cop_mem_error;
        end
    end

    // A completing transaction and a fresh issue may share a cycle; issue takes precedence.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        hold_wen_d   = hold_wen_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_ben_d   = hold_ben_q;
        if (issue) begin
            state_d      = ST_BUSY;
            owner_d      = sel;
            last_d       = sel;
            hold_wen_d   = sel_wen;
            hold_addr_d  = sel_addr;
            hold_wdata_d = sel_wdata;
            hold_ben_d   = sel_ben;
        end else if (complete) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            hold_wen_q   <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_ben_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            hold_wen_q   <= hold_wen_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_ben_q   <= hold_ben_d;
        end
    end

endmodule

// File: tb/tb_cop_mem_arbiter.sv
// Directed bench for cop_mem_arbiter: a round-robin instance and a fixed-priority instance share stimulus.
`timescale 1ns/1ps
module tb_cop_mem_arbiter;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        rq0_cen, rq0_wen, rq1_cen, rq1_wen;
    logic [31:0] rq0_addr, rq0_wdata, rq1_addr, rq1_wdata;
    logic [3:0]  rq0_ben, rq1_ben;
    logic [31:0] cop_mem_rdata;
    logic        cop_mem_stall, cop_mem_error;

    logic        rq0_gnt, rq0_rsp, rq0_error, rq1_gnt, rq1_rsp, rq1_error;
    logic [31:0] rq0_rdata, rq1_rdata;
    logic        cop_mem_cen, cop_mem_wen;
    logic [31:0] cop_mem_addr, cop_mem_wdata;
    logic [3:0]  cop_mem_ben;

    logic        fp_rq0_gnt, fp_rq0_rsp, fp_rq0_error, fp_rq1_gnt, fp_rq1_rsp, fp_rq1_error;
    logic [31:0] fp_rq0_rdata, fp_rq1_rdata;
    logic        fp_cop_mem_cen, fp_cop_mem_wen;
    logic [31:0] fp_cop_mem_addr, fp_cop_mem_wdata;
    logic [3:0]  fp_cop_mem_ben;

    int n_vec = 0;
    int n_err = 0;

    always #5 g_clk = ~g_clk;

    cop_mem_arbiter #(.FIXED_PRIO(0)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .rq0_cen(rq0_cen), .rq0_wen(rq0_wen), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq0_ben(rq0_ben), .rq0_gnt(rq0_gnt), .rq0_rsp(rq0_rsp), .rq0_rdata(rq0_rdata),
        .rq0_error(rq0_error),
        .rq1_cen(rq1_cen), .rq1_wen(rq1_wen), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rq1_ben(rq1_ben), .rq1_gnt(rq1_gnt), .rq1_rsp(rq1_rsp), .rq1_rdata(rq1_rdata),
        .rq1_error(rq1_error),
        .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen), .cop_mem_addr(cop_mem_addr),
        .cop_mem_wdata(cop_mem_wdata), .cop_mem_ben(cop_mem_ben), .cop_mem_rdata(cop_mem_rdata),
        .cop_mem_stall(cop_mem_stall), .cop_mem_error(cop_mem_error)
    );

    cop_mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .g_clk(g_clk), .g_reset(g_reset),
        .rq0_cen(rq0_cen), .rq0_wen(rq0_wen), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq0_ben(rq0_ben), .rq0_gnt(fp_rq0_gnt), .rq0_rsp(fp_rq0_rsp), .rq0_rdata(fp_rq0_rdata),
        .rq0_error(fp_rq0_error),
        .rq1_cen(rq1_cen), .rq1_wen(rq1_wen), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rq1_ben(rq1_ben), .rq1_gnt(fp_rq1_gnt), .rq1_rsp(fp_rq1_rsp), .rq1_rdata(fp_rq1_rdata),
        .rq1_error(fp_rq1_error),
        .cop_mem_cen(fp_cop_mem_cen), .cop_mem_wen(fp_cop_mem_wen), .cop_mem_addr(fp_cop_mem_addr),
        .cop_mem_wdata(fp_cop_mem_wdata), .cop_mem_ben(fp_cop_mem_ben), .cop_mem_rdata(cop_mem_rdata),
        .cop_mem_stall(cop_mem_stall), .cop_mem_error(cop_mem_error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rq0_cen = 1'b0; rq0_wen = 1'b0; rq0_addr = '0; rq0_wdata = '0; rq0_ben = '0;
        rq1_cen = 1'b0; rq1_wen = 1'b0; rq1_addr = '0; rq1_wdata = '0; rq1_ben = '0;
        cop_mem_rdata = '0; cop_mem_stall = 1'b0; cop_mem_error = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge g_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge g_clk);
    endtask

    // Protocol monitor on the round-robin instance: an ungranted request must stay asserted.
    logic pend0 = 1'b0;
    logic pend1 = 1'b0;
    always @(negedge g_clk) begin
        if (g_reset) begin
            pend0 = 1'b0;
            pend1 = 1'b0;
        end else begin
            if (pend0) chk("hold0", {31'd0, rq0_cen}, 32'd1);
            if (pend1) chk("hold1", {31'd0, rq1_cen}, 32'd1);
            pend0 = rq0_cen && !rq0_gnt;
            pend1 = rq1_cen && !rq1_gnt;
        end
    end

    logic [3:0]  rr_g0, rr_rsp0, rr_rsp1;
    logic [31:0] rd;

    initial begin
        idle_inputs();
        g_reset = 1'b1;
        rq0_cen = 1'b1; rq0_addr = 32'h100; rq1_cen = 1'b1;
        cop_mem_rdata = 32'hCAFE0000; cop_mem_error = 1'b1;
        mid();
        chk("rst_cen",   {31'd0, cop_mem_cen}, 32'd0);
        chk("rst_addr",  cop_mem_addr, 32'd0);
        chk("rst_gnt0",  {31'd0, rq0_gnt}, 32'd0);
        chk("rst_gnt1",  {31'd0, rq1_gnt}, 32'd0);
        chk("rst_rsp0",  {31'd0, rq0_rsp}, 32'd0);
        chk("rst_rdata0", rq0_rdata, 32'd0);
        chk("rst_err0",  {31'd0, rq0_error}, 32'd0);
        next_cycle();
        idle_inputs();
        g_reset = 1'b0;

        // Conflict: both requesters held four cycles; last = 1 after reset so rq0 goes first.
        rr_g0 = 4'b0101; rr_rsp0 = 4'b1010; rr_rsp1 = 4'b0100;
        rq0_cen = 1'b1; rq0_addr = 32'h10; rq0_ben = 4'hF;
        rq1_cen = 1'b1; rq1_addr = 32'h20; rq1_ben = 4'hF;
        for (int k = 0; k < 4; k++) begin
            rd = 32'hA0000000 + k;
            cop_mem_rdata = rd;
            mid();
            chk("rr_gnt0", {31'd0, rq0_gnt}, {31'd0, rr_g0[k]});
            chk("rr_gnt1", {31'd0, rq1_gnt}, {31'd0, !rr_g0[k]});
            chk("rr_addr", cop_mem_addr, rr_g0[k] ? 32'h10 : 32'h20);
            chk("rr_rsp0", {31'd0, rq0_rsp}, {31'd0, rr_rsp0[k]});
            chk("rr_rsp1", {31'd0, rq1_rsp}, {31'd0, rr_rsp1[k]});
            chk("rr_rdata0", rq0_rdata, rr_rsp0[k] ? rd : 32'd0);
            chk("rr_rdata1", rq1_rdata, rr_rsp1[k] ? rd : 32'd0);
            chk("fp_gnt0", {31'd0, fp_rq0_gnt}, 32'd1);
            chk("fp_gnt1", {31'd0, fp_rq1_gnt}, 32'd0);
            chk("fp_mem", {fp_cop_mem_addr[27:0], fp_cop_mem_ben}, {28'h10, 4'hF});
            chk("fp_mem_wr", {fp_cop_mem_wdata[29:0], fp_cop_mem_cen, fp_cop_mem_wen}, 32'h2);
            chk("fp_rsp0", {31'd0, fp_rq0_rsp}, (k >= 1) ? 32'd1 : 32'd0);
            chk("fp_rdata0", fp_rq0_rdata, (k >= 1) ? rd : 32'd0);
            chk("fp_rsp1", {fp_rq1_rdata[29:0], fp_rq1_error, fp_rq1_rsp}, 32'd0);
            chk("fp_err0", {31'd0, fp_rq0_error}, 32'd0);
            next_cycle();
        end
        rq1_cen = 1'b0; rq1_addr = '0; rq1_ben = '0;
        cop_mem_rdata = 32'hA0000004;
        mid();
        chk("rr4_gnt0", {31'd0, rq0_gnt}, 32'd1);
        chk("rr4_gnt1", {31'd0, rq1_gnt}, 32'd0);
        chk("rr4_rsp1", {31'd0, rq1_rsp}, 32'd1);
        chk("rr4_rdata1", rq1_rdata, 32'hA0000004);
        chk("rr4_rsp0", {31'd0, rq0_rsp}, 32'd0);
        chk("fp4_rsp0", {31'd0, fp_rq0_rsp}, 32'd1);
        next_cycle();
        idle_inputs();
        cop_mem_rdata = 32'hB5;
        mid();
        chk("rr5_rsp0", {31'd0, rq0_rsp}, 32'd1);
        chk("rr5_rdata0", rq0_rdata, 32'hB5);
        chk("rr5_cen", {31'd0, cop_mem_cen}, 32'd0);
        chk("rr5_addr", cop_mem_addr, 32'd0);
        chk("fp5_rsp0", {31'd0, fp_rq0_rsp}, 32'd1);
        next_cycle();
        mid();
        chk("idle_rsp", {30'd0, rq0_rsp, rq1_rsp}, 32'd0);
        next_cycle();

        // Stall on an rq1 write; stall is also high in the issue cycle, where it is ignored.
        rq1_cen = 1'b1; rq1_wen = 1'b1; rq1_addr = 32'h200; rq1_wdata = 32'h12345678; rq1_ben = 4'hF;
        cop_mem_stall = 1'b1;
        mid();
        chk("st_gnt1", {31'd0, rq1_gnt}, 32'd1);
        chk("st_cen", {31'd0, cop_mem_cen}, 32'd1);
        chk("st_wen", {31'd0, cop_mem_wen}, 32'd1);
        chk("st_addr", cop_mem_addr, 32'h200);
        chk("st_wdata", cop_mem_wdata, 32'h12345678);
        chk("st_ben", {28'd0, cop_mem_ben}, 32'hF);
        next_cycle();
        rq1_cen = 1'b0; rq1_wen = 1'b0; rq1_addr = '0; rq1_wdata = '0; rq1_ben = '0;
        rq0_cen = 1'b1; rq0_addr = 32'h300; rq0_ben = 4'hF;
        cop_mem_rdata = 32'h99;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("stl_gnt", {30'd0, rq0_gnt, rq1_gnt}, 32'd0);
            chk("stl_rsp", {30'd0, rq0_rsp, rq1_rsp}, 32'd0);
            chk("stl_cen", {31'd0, cop_mem_cen}, 32'd1);
            chk("stl_wen", {31'd0, cop_mem_wen}, 32'd1);
            chk("stl_addr", cop_mem_addr, 32'h200);
            chk("stl_wdata", cop_mem_wdata, 32'h12345678);
            chk("stl_ben", {28'd0, cop_mem_ben}, 32'hF);
            next_cycle();
        end
        cop_mem_stall = 1'b0;
        cop_mem_rdata = 32'h55;
        mid();
        chk("sd_rsp1", {31'd0, rq1_rsp}, 32'd1);
        chk("sd_rdata1", rq1_rdata, 32'h55);
        chk("sd_err1", {31'd0, rq1_error}, 32'd0);
        chk("sd_rsp0", {31'd0, rq0_rsp}, 32'd0);
        chk("sd_gnt0", {31'd0, rq0_gnt}, 32'd1);
        chk("sd_addr", cop_mem_addr, 32'h300);
        chk("sd_wen", {31'd0, cop_mem_wen}, 32'd0);
        next_cycle();

        // Error on rq0's read response, then rq1 proceeds normally.
        idle_inputs();
        cop_mem_error = 1'b1; cop_mem_rdata = 32'h77;
        mid();
        chk("er_rsp0", {31'd0, rq0_rsp}, 32'd1);
        chk("er_err0", {31'd0, rq0_error}, 32'd1);
        chk("er_rdata0", rq0_rdata, 32'h77);
        chk("er_err1", {31'd0, rq1_error}, 32'd0);
        chk("er_rsp1", {31'd0, rq1_rsp}, 32'd0);
        next_cycle();
        idle_inputs();
        rq1_cen = 1'b1; rq1_addr = 32'h400; rq1_ben = 4'hF;
        mid();
        chk("er_gnt1", {31'd0, rq1_gnt}, 32'd1);
        chk("er_addr", cop_mem_addr, 32'h400);
        chk("er_rsp0b", {31'd0, rq0_rsp}, 32'd0);
        next_cycle();
        idle_inputs();
        cop_mem_rdata = 32'h66;
        mid();
        chk("er_rsp1b", {31'd0, rq1_rsp}, 32'd1);
        chk("er_rdata1", rq1_rdata, 32'h66);
        chk("er_err1b", {31'd0, rq1_error}, 32'd0);
        next_cycle();

        // Reset pulsed while rq0's read is stalled and rq1 is waiting.
        rq0_cen = 1'b1; rq0_addr = 32'h500; rq0_ben = 4'hF;
        mid();
        chk("rs_gnt0", {31'd0, rq0_gnt}, 32'd1);
        next_cycle();
        rq0_cen = 1'b0; rq0_addr = '0;
        rq1_cen = 1'b1; rq1_addr = 32'h600;
        cop_mem_stall = 1'b1;
        mid();
        chk("rs_stl_cen", {31'd0, cop_mem_cen}, 32'd1);
        chk("rs_stl_addr", cop_mem_addr, 32'h500);
        chk("rs_stl_gnt1", {31'd0, rq1_gnt}, 32'd0);
        #2;
        g_reset = 1'b1;
        cop_mem_stall = 1'b0;
        cop_mem_rdata = 32'h88;
        #1;
        chk("rs_cen", {31'd0, cop_mem_cen}, 32'd0);
        chk("rs_addr", cop_mem_addr, 32'd0);
        chk("rs_rsp0", {31'd0, rq0_rsp}, 32'd0);
        chk("rs_rdata0", rq0_rdata, 32'd0);
        chk("rs_gnt1", {31'd0, rq1_gnt}, 32'd0);
        next_cycle();
        rq0_cen = 1'b1; rq0_addr = 32'h700;
        mid();
        chk("rs_hold_gnt", {30'd0, rq0_gnt, rq1_gnt}, 32'd0);
        next_cycle();
        g_reset = 1'b0;
        mid();
        chk("rl_gnt0", {31'd0, rq0_gnt}, 32'd1);
        chk("rl_gnt1", {31'd0, rq1_gnt}, 32'd0);
        chk("rl_rsp", {30'd0, rq0_rsp, rq1_rsp}, 32'd0);
        chk("rl_addr", cop_mem_addr, 32'h700);
        chk("rl_fp_gnt0", {31'd0, fp_rq0_gnt}, 32'd1);
        next_cycle();
        rq0_cen = 1'b0; rq0_addr = '0;
        mid();
        chk("rl2_gnt1", {31'd0, rq1_gnt}, 32'd1);
        chk("rl2_rsp0", {31'd0, rq0_rsp}, 32'd1);
        chk("rl2_addr", cop_mem_addr, 32'h600);
        next_cycle();
        idle_inputs();
        mid();
        chk("rl3_rsp1", {31'd0, rq1_rsp}, 32'd1);
        chk("rl3_cen", {31'd0, cop_mem_cen}, 32'd0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
